// File: rtl/tcdm_bank_arb_resp_demux_if.sv
// tcdm_bank_arb_resp_demux_if: master-side request/response and bank-side signals of one TCDM bank port
interface tcdm_bank_arb_resp_demux_if #(
  parameter int NumIn = 32,
  parameter int ReqDataWidth = 32,
  parameter int RespDataWidth = 32
);
  logic [NumIn-1:0] req_i;
  logic [NumIn-1:0] we_i;
  logic [NumIn-1:0][ReqDataWidth-1:0] data_i;
  logic [NumIn-1:0] gnt_o;
  logic [NumIn-1:0] vld_o;
  logic [RespDataWidth-1:0] rdata_o;
  logic req_o;
  logic we_o;
  logic [ReqDataWidth-1:0] data_o;
  logic gnt_i;
  logic [RespDataWidth-1:0] rdata_i;
  modport slave (
    input req_i, we_i, data_i, gnt_i, rdata_i,
    output gnt_o, vld_o, rdata_o, req_o, we_o, data_o
  );
  modport master (
    output req_i, we_i, data_i, gnt_i, rdata_i,
    input gnt_o, vld_o, rdata_o, req_o, we_o, data_o
  );
endinterface

// File: rtl/tcdm_bank_arb_resp_demux.sv
// tcdm_bank_arb_resp_demux: round-robin bank arbiter with a latency-matched response demux
module tcdm_bank_arb_resp_demux #(
  parameter int NumIn = 32,
  parameter int ReqDataWidth = 32,
  parameter int RespDataWidth = 32,
  parameter int RespLat = 1,
  parameter bit WriteRespOn = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  tcdm_bank_arb_resp_demux_if.slave bus
);
  localparam int IW = NumIn > 1 ? $clog2(NumIn) : 1;
  logic [IW-1:0] rr_q, rr_d, win;
  logic hs;
  logic [RespLat-1:0] vld_q;
  logic [IW-1:0] idx_q [RespLat];
  // descending scan so the lowest offset from rr_q wins
  always_comb begin
    win = '0;
    for (int k = NumIn - 1; k >= 0; k--)
      if (bus.req_i[(int'(rr_q) + k) % NumIn]) win = IW'((int'(rr_q) + k) % NumIn);
  end
  assign bus.req_o = |bus.req_i & ~rst_i;
  assign bus.we_o = bus.we_i[win];
  assign bus.data_o = bus.data_i[win];
  assign hs = bus.req_o & bus.gnt_i;
  assign bus.gnt_o = hs ? NumIn'(1) << win : '0;
  assign bus.vld_o = (vld_q[RespLat-1] & ~rst_i) ? NumIn'(1) << idx_q[RespLat-1] : '0;
  assign bus.rdata_o = bus.rdata_i;
  assign rr_d = hs ? ((int'(win) == NumIn - 1) ? '0 : win + 1'b1) : rr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < RespLat; s++) idx_q[s] <= '0;
    end else begin
      rr_q <= rr_d;
      vld_q[0] <= hs & (~bus.we_o | WriteRespOn);
      idx_q[0] <= win;
      for (int s = 1; s < RespLat; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    assert (RespLat >= 1 && NumIn >= 1) else $fatal(1, "RespLat and NumIn must be >= 1");
    assert ($onehot0(bus.gnt_o) && $onehot0(bus.vld_o)) else $error("gnt_o/vld_o not onehot0");
  end
endmodule

// File: tb/tb_tcdm_bank_arb_resp_demux.sv
// tb_tcdm_bank_arb_resp_demux: directed vectors across four arbiter configurations
module tb_tcdm_bank_arb_resp_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  tcdm_bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) a ();
  tcdm_bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) b ();
  tcdm_bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) c ();
  tcdm_bank_arb_resp_demux_if #(.NumIn(3), .ReqDataWidth(32), .RespDataWidth(32)) d ();
  tcdm_bank_arb_resp_demux #(.NumIn(4), .RespLat(1), .WriteRespOn(1'b1)) u_a (.clk_i(clk), .rst_i(rst), .bus(a));
  tcdm_bank_arb_resp_demux #(.NumIn(4), .RespLat(3), .WriteRespOn(1'b1)) u_b (.clk_i(clk), .rst_i(rst), .bus(b));
  tcdm_bank_arb_resp_demux #(.NumIn(4), .RespLat(2), .WriteRespOn(1'b0)) u_c (.clk_i(clk), .rst_i(rst), .bus(c));
  tcdm_bank_arb_resp_demux #(.NumIn(3), .RespLat(1), .WriteRespOn(1'b1)) u_d (.clk_i(clk), .rst_i(rst), .bus(d));
  logic [3:0] g1 [6] = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};
  logic [3:0] v1 [7] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};
  logic [3:0] r3 [6] = '{4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] v3 [6] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0};
  logic [3:0] r4 [5] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
  logic [3:0] w4 [5] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] v4 [5] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
  logic [2:0] g6 [4] = '{3'h1, 3'h2, 3'h4, 3'h1};
  logic [2:0] v6 [4] = '{3'h0, 3'h1, 3'h2, 3'h4};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    a.req_i = '0; a.we_i = '0; a.gnt_i = 1'b0; a.rdata_i = '0;
    b.req_i = '0; b.we_i = '0; b.gnt_i = 1'b0; b.rdata_i = '0;
    c.req_i = '0; c.we_i = '0; c.gnt_i = 1'b0; c.rdata_i = '0;
    d.req_i = '0; d.we_i = '0; d.gnt_i = 1'b0; d.rdata_i = '0;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    clr();
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    clr();
    for (int i = 0; i < 4; i++) begin
      a.data_i[i] = 32'hA000_0000 + i;
      b.data_i[i] = 32'hB000_0000 + i;
      c.data_i[i] = 32'hC000_0000 + i;
    end
    for (int i = 0; i < 3; i++) d.data_i[i] = 32'hD000_0000 + i;
    a.req_i = 4'b1111;
    a.gnt_i = 1'b1;
    #3;
    chk("rst_gnt", a.gnt_o, 0);
    chk("rst_req", a.req_o, 0);
    chk("rst_vld", a.vld_o, 0);
    cyc();
    rst_pulse();
    a.req_i = 4'b1011;
    a.gnt_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) a.req_i = '0;
      a.rdata_i = 32'h1234_0000 + k;
      #3;
      if (k < 6) chk("rr_gnt", a.gnt_o, g1[k]);
      chk("rr_vld", a.vld_o, v1[k]);
      chk("rr_rdata", a.rdata_o, 32'h1234_0000 + k);
      cyc();
    end
    rst_pulse();
    a.req_i = 4'b0110;
    a.we_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("stall_gnt", a.gnt_o, 0);
      chk("stall_req", a.req_o, 1);
      chk("stall_data", a.data_o, 32'hA000_0001);
      chk("stall_we", a.we_o, 0);
      cyc();
    end
    a.gnt_i = 1'b1;
    #3;
    chk("stall_gnt1", a.gnt_o, 4'b0010);
    cyc();
    #3;
    chk("stall_gnt2", a.gnt_o, 4'b0100);
    chk("stall_we2", a.we_o, 1);
    chk("stall_data2", a.data_o, 32'hA000_0002);
    cyc();
    rst_pulse();
    b.gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b.req_i = r3[k];
      b.rdata_i = 32'hBEEF_0000 + k;
      #3;
      chk("lat3_gnt", b.gnt_o, r3[k]);
      chk("lat3_vld", b.vld_o, v3[k]);
      chk("lat3_rdata", b.rdata_o, 32'hBEEF_0000 + k);
      cyc();
    end
    rst_pulse();
    c.gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c.req_i = r4[k];
      c.we_i = w4[k];
      #3;
      chk("wr_gnt", c.gnt_o, r4[k]);
      chk("wr_vld", c.vld_o, v4[k]);
      cyc();
    end
    rst_pulse();
    c.req_i = 4'b0001;
    c.gnt_i = 1'b1;
    #3;
    chk("mid_gnt0", c.gnt_o, 4'b0001);
    cyc();
    rst = 1'b1;
    c.req_i = 4'b1111;
    #3;
    chk("mid_rst_gnt", c.gnt_o, 0);
    chk("mid_rst_req", c.req_o, 0);
    chk("mid_rst_vld", c.vld_o, 0);
    cyc();
    rst = 1'b0;
    #3;
    chk("mid_drop_vld", c.vld_o, 0);
    chk("mid_post_gnt", c.gnt_o, 4'b0001);
    cyc();
    #3;
    chk("mid_vld3", c.vld_o, 0);
    chk("mid_gnt3", c.gnt_o, 4'b0010);
    cyc();
    #3;
    chk("mid_vld4", c.vld_o, 4'b0001);
    cyc();
    rst_pulse();
    d.req_i = 3'b111;
    d.gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("n3_gnt", d.gnt_o, g6[k]);
      chk("n3_vld", d.vld_o, v6[k]);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tcdm_bank_arb_resp_demux.md
Name: tcdm_bank_arb_resp_demux

Overview:
- Slave-side counterpart of the per-master address decoder / response mux in the TCDM full crossbar. One instance sits in front of each memory bank.
- Arbitrates round-robin among NumIn master requests and forwards the winner to the bank.
- Tracks the winner index through a RespLat-deep pipeline and steers the bank's valid/response back to the originating master.

Parameters:
- NumIn, 32: number of master ports; must be >= 1.
- ReqDataWidth, 32: width of the request payload (address/wdata/be bundle).
- RespDataWidth, 32: width of the read data.
- RespLat, 1: bank response latency in cycles; must be >= 1.
- WriteRespOn, 1'b1: 1 = writes return vld; 0 = only reads return vld.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumIn  per-master request.
- we_i  in  NumIn  per-master write flag (1 = write, 0 = read).
- data_i  in  NumIn x ReqDataWidth  per-master payload.
- gnt_o  out  NumIn  per-master grant, one-hot or zero.
- vld_o  out  NumIn  per-master response valid, one-hot or zero.
- rdata_o  out  RespDataWidth  response data, broadcast to all masters (qualified by vld_o).
- req_o  out  1  request to bank.
- we_o  out  1  write flag of the winner.
- data_o  out  ReqDataWidth  payload of the winner.
- gnt_i  in  1  bank ready/grant.
- rdata_i  in  RespDataWidth  bank read data, valid RespLat cycles after the handshake.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - rr_q <= 0; all vld/idx pipeline stages <= 0.
  - While rst_i is high: req_o=0, gnt_o=0, vld_o=0 (forced combinationally).
  - In-flight responses are dropped, never delivered.
- Arbitration (combinational):
  - winner = first index i with req_i[i]=1, scanning rr_q, rr_q+1, ... NumIn-1, 0, ... rr_q-1 (modulo NumIn).
  - req_o = |req_i; we_o = we_i[winner]; data_o = data_i[winner].
  - With no request, we_o and data_o = index-0 values (don't care).
- Grant:
  - gnt_o[winner] = req_o & gnt_i; all other bits are 0.
  - gnt_o may depend combinationally on gnt_i; no combinational path from gnt_i to req_o.
- Pointer update:
  - On a handshake (req_o & gnt_i): rr_q <= (winner == NumIn-1) ? 0 : winner+1.
  - Otherwise rr_q holds. A stalled bank does not rotate priority; a lone requester keeps its slot until served.
- Response pipeline, RespLat stages of {vld, idx}:
  - Stage 0 input: vld = req_o & gnt_i & (~we_o | WriteRespOn); idx = winner.
  - Each stage shifts every cycle with no stall; one response per cycle max.
  - vld_o[idx_last] = vld_last; all other vld_o bits are 0.
  - rdata_o = rdata_i, pass-through with no register.
- Latency: handshake at edge N -> vld_o asserted in the cycle after edge N+RespLat-1, i.e. exactly RespLat cycles after gnt_o.
- Back-to-back handshakes every cycle are supported, including different masters on consecutive cycles.
- NumIn=1: winner is always 0, no rr_q state required (index width = 1 bit internally); behaviour otherwise identical.
- Writes with WriteRespOn=0: gnt_o is still issued; no vld_o follows.
- Index width: max(1, $clog2(NumIn)). The modulo wrap must be correct for non-power-of-two NumIn.
- Simulation-only checks: fatal if RespLat==0 or NumIn==0; assert gnt_o and vld_o are $onehot0 every cycle.

Test Plan:
- NumIn=4, RespLat=1, gnt_i=1, req_i=4'b1011 held 6 cycles -> gnt_o sequence 0001, 0010, 1000, 0001, 0010, 1000; vld_o repeats that sequence one cycle later; rdata_o follows rdata_i.
- Bank stall: req_i=4'b0110, gnt_i=0 for 3 cycles, then 1 -> gnt_o=0 during the stall and rr_q unchanged; the first grant goes to master 1, the next to master 2.
- RespLat=3, master 2 read at cycle 5, master 0 read at cycle 6 -> vld_o=0100 at cycle 8, vld_o=0001 at cycle 9, rdata_o = rdata_i in those cycles.
- WriteRespOn=0: master 1 write granted, then master 1 read granted -> no vld_o for the write; vld_o=0010 RespLat cycles after the read grant only.
- Reset mid-flight: RespLat=2, grant at cycle 3, rst_i=1 at cycle 4 -> no vld_o at cycle 5; rr_q=0, so the first post-reset grant with req_i=1111 goes to master 0.
- NumIn=3, non-power-of-two: req_i=3'b111 continuous -> grants 001, 010, 100, 001 with correct wrap and no out-of-range index.
